// File: rtl/aes_block_scheduler_if.sv
// ----------------------------------------------------------------------------
// aes_block_scheduler_if
//   Bundles every non-clock/reset signal between the AES block scheduler and
//   its environment (UART RX byte stream, encrypt core, UART TX handshake and
//   status flags).
//
//   slave  : the scheduler's view (consumes rx/core/tx_ready, drives the rest)
//   master : the environment's view (UART RX, encrypt core, UART TX)
//
//   rx_byte/rx_valid      received byte + 1-cycle strobe
//   enc_data/enc_start    plaintext block + 1-cycle launch pulse to the core
//   enc_result/enc_done   ciphertext + 1-cycle completion strobe from the core
//   tx_byte/tx_valid      byte to UART TX, held until tx_ready
//   tx_ready              UART TX can accept
//   busy                  scheduler holds a partial or in-flight block
//   overrun               1-cycle pulse: rx byte dropped
//   rx_timeout            1-cycle pulse: partial block discarded
//   enc_timeout           1-cycle pulse: core did not answer in time
// ----------------------------------------------------------------------------
interface aes_block_scheduler_if;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [127:0] enc_data;
    logic         enc_start;
    logic [127:0] enc_result;
    logic         enc_done;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         overrun;
    logic         rx_timeout;
    logic         enc_timeout;

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  enc_result,
        input  enc_done,
        input  tx_ready,
        output enc_data,
        output enc_start,
        output tx_byte,
        output tx_valid,
        output busy,
        output overrun,
        output rx_timeout,
        output enc_timeout
    );

    modport master (
        output rx_byte,
        output rx_valid,
        output enc_result,
        output enc_done,
        output tx_ready,
        input  enc_data,
        input  enc_start,
        input  tx_byte,
        input  tx_valid,
        input  busy,
        input  overrun,
        input  rx_timeout,
        input  enc_timeout
    );
endinterface

// File: rtl/aes_block_scheduler.sv
// ----------------------------------------------------------------------------
// aes_block_scheduler
//   Sequences the AES encrypt datapath between UART RX and UART TX. Sixteen
//   received bytes are packed into one 128-bit block (first byte ends up in
//   [127:120]), the core is launched with a 1-cycle enc_start pulse, and the
//   16 result bytes are returned MSB-byte first over a valid/ready handshake.
//   All framing, idle/core timeouts and error flags live here so the core only
//   ever sees whole blocks.
//
// Parameters
//   CLOCK_PER_BIT  clk cycles per UART bit
//   RX_IDLE_MAX    idle cycles allowed inside a partial block before discard
//   ENC_MAX        cycles allowed in WAIT before the core is declared hung
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   aes_block_scheduler_if.slave (rx, core, tx and status signals)
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module aes_block_scheduler #(
    parameter int unsigned CLOCK_PER_BIT = 10417,
    parameter int unsigned RX_IDLE_MAX   = CLOCK_PER_BIT * 160,
    parameter int unsigned ENC_MAX       = CLOCK_PER_BIT * 200
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_block_scheduler_if.slave  bus
);

    // A counter "reaches" its limit on the edge where it would step from
    // limit-1 to limit, so the compare is done against limit-1.
    localparam logic [31:0] IdleLast = 32'(RX_IDLE_MAX - 1);
    localparam logic [31:0] WaitLast = 32'(ENC_MAX - 1);

    typedef enum logic [1:0] {
        StCollect,
        StLaunch,
        StWait,
        StSend
    } state_e;

    state_e       state_q;
    logic [4:0]   count_q;      // bytes held in the current block, 0..16
    logic [31:0]  idle_q;       // cycles since last rx byte of a partial block
    logic [31:0]  wait_q;       // cycles spent in WAIT
    logic [127:0] data_q;       // plaintext shift register, drives enc_data
    logic [127:0] res_q;        // remaining result bytes, next byte in [127:120]
    logic [3:0]   idx_q;        // index of the byte currently offered on tx
    logic [7:0]   tx_byte_q;
    logic         tx_valid_q;
    logic         enc_start_q;
    logic         busy_q;
    logic         overrun_q;
    logic         rx_timeout_q;
    logic         enc_timeout_q;

    logic idle_expired;
    logic wait_expired;

    assign idle_expired = (count_q != 5'd0) && (idle_q >= IdleLast);
    assign wait_expired = (wait_q >= WaitLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StCollect;
            count_q       <= 5'd0;
            idle_q        <= 32'd0;
            wait_q        <= 32'd0;
            data_q        <= 128'd0;
            res_q         <= 128'd0;
            idx_q         <= 4'd0;
            tx_byte_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            enc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            rx_timeout_q  <= 1'b0;
            enc_timeout_q <= 1'b0;
        end else begin
            // Pulse outputs default low; each branch raises them for one cycle.
            enc_start_q   <= 1'b0;
            overrun_q     <= 1'b0;
            rx_timeout_q  <= 1'b0;
            enc_timeout_q <= 1'b0;

            case (state_q)
                StCollect: begin
                    if (count_q == 5'd16) begin
                        // Block complete: launch next edge. A byte arriving in
                        // this hand-off cycle has no slot and is dropped.
                        state_q     <= StLaunch;
                        enc_start_q <= 1'b1;
                        count_q     <= 5'd0;
                        idle_q      <= 32'd0;
                        overrun_q   <= bus.rx_valid;
                    end else begin
                        rx_timeout_q <= idle_expired;
                        if (bus.rx_valid) begin
                            // On a simultaneous timeout the byte wins and opens
                            // a fresh block; stale bytes shift out as it fills.
                            data_q  <= {data_q[119:0], bus.rx_byte};
                            count_q <= idle_expired ? 5'd1 : count_q + 5'd1;
                            idle_q  <= 32'd0;
                            busy_q  <= 1'b1;
                        end else if (idle_expired) begin
                            // Discard the partial block; enc_data is left as is.
                            count_q <= 5'd0;
                            idle_q  <= 32'd0;
                            busy_q  <= 1'b0;
                        end else if ((count_q != 5'd0) && (idle_q != '1)) begin
                            idle_q <= idle_q + 32'd1;
                        end
                    end
                end

                StLaunch: begin
                    state_q   <= StWait;
                    wait_q    <= 32'd0;
                    overrun_q <= bus.rx_valid;
                end

                StWait: begin
                    overrun_q <= bus.rx_valid;
                    if (bus.enc_done) begin
                        // Done has priority over a timeout on the same edge.
                        res_q      <= {bus.enc_result[119:0], 8'd0};
                        tx_byte_q  <= bus.enc_result[127:120];
                        tx_valid_q <= 1'b1;
                        idx_q      <= 4'd0;
                        state_q    <= StSend;
                    end else if (wait_expired) begin
                        enc_timeout_q <= 1'b1;
                        state_q       <= StCollect;
                        count_q       <= 5'd0;
                        busy_q        <= 1'b0;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + 32'd1;
                    end
                end

                StSend: begin
                    overrun_q <= bus.rx_valid;
                    // tx_byte only moves on acceptance, so it is stable while stalled.
                    if (tx_valid_q && bus.tx_ready) begin
                        if (idx_q == 4'd15) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= StCollect;
                            count_q    <= 5'd0;
                            busy_q     <= 1'b0;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_byte_q <= res_q[127:120];
                            res_q     <= {res_q[119:0], 8'd0};
                        end
                    end
                end

                default: begin
                    state_q <= StCollect;
                    count_q <= 5'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enc_data    = data_q;
    assign bus.enc_start   = enc_start_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.rx_timeout  = rx_timeout_q;
    assign bus.enc_timeout = enc_timeout_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// ----------------------------------------------------------------------------
// tb_aes_block_scheduler
//   Self-checking bench for aes_block_scheduler with shortened timeouts.
//   A stub core answers enc_start with ~enc_data after a programmable delay.
//   Expected blocks/bytes come from the byte list sent (pb[]), placed by index.
// ----------------------------------------------------------------------------
module tb_aes_block_scheduler;

    localparam int IdleMax = 100;
    localparam int EncMax  = 200;

    logic clk = 1'b0;
    logic rst;

    aes_block_scheduler_if bus ();

    aes_block_scheduler #(
        .RX_IDLE_MAX (IdleMax),
        .ENC_MAX     (EncMax)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- cycle counter and passive monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_start = 0, n_ovr = 0, n_rxto = 0, n_encto = 0, n_stall_viol = 0;
    int last_rx_cyc = 0, start_cyc = 0, done_cyc = 0, first_tx_cyc = 0;
    int ovr_cyc = 0, rxto_cyc = 0, encto_cyc = 0;
    logic [127:0] start_data = '0;
    logic [127:0] done_data  = '0;
    logic [7:0]   tx_q[$];
    logic         prev_valid = 1'b0;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_byte  = 8'd0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) last_rx_cyc = cyc;
            if (bus.enc_start) begin
                n_start++;
                start_cyc  = cyc;
                start_data = bus.enc_data;
            end
            if (bus.enc_done) begin
                done_cyc  = cyc;
                done_data = bus.enc_data;
            end
            if (bus.tx_valid && !prev_valid) first_tx_cyc = cyc;
            if (bus.overrun) begin n_ovr++; ovr_cyc = cyc; end
            if (bus.rx_timeout) begin n_rxto++; rxto_cyc = cyc; end
            if (bus.enc_timeout) begin n_encto++; encto_cyc = cyc; end
            if (prev_stall && (!bus.tx_valid || bus.tx_byte !== prev_byte)) n_stall_viol++;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_byte);
        end
        prev_valid = bus.tx_valid && !rst;
        prev_stall = bus.tx_valid && !bus.tx_ready && !rst;
        prev_byte  = bus.tx_byte;
    end

    // ---------------- stub encrypt core ----------------
    int           core_lat   = 50;
    bit           core_never = 1'b0;
    logic [127:0] core_d;

    initial begin
        bus.enc_done   = 1'b0;
        bus.enc_result = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.enc_start && !core_never) begin
                core_d = bus.enc_data;
                repeat (core_lat) @(posedge clk);
                #1;
                bus.enc_done   = 1'b1;
                bus.enc_result = ~core_d;
                @(posedge clk); #1;
                bus.enc_done   = 1'b0;
                bus.enc_result = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    end

    // ---------------- tx_ready driver ----------------
    // 0: always ready, 1: random (~75%), 2: one cycle low then three high
    int ready_mode = 0;
    int rdy_ph     = 0;

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rdy_ph = (rdy_ph + 1) % 4;
            case (ready_mode)
                1:       bus.tx_ready = (($urandom() % 4) != 0);
                2:       bus.tx_ready = (rdy_ph != 0);
                default: bus.tx_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers and model ----------------
    logic [7:0] pb [16];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom());
    endtask

    task automatic send_block(input int max_gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(pb[i]);
            if (i < 15) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) pb[i] = 8'($urandom());
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (tx_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        ok = (tx_q.size() >= n);
    endtask

    // Byte i of the block occupies bits [127-8i -: 8].
    function automatic logic [127:0] model_block();
        logic [127:0] blk;
        blk = '0;
        for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = pb[i];
        return blk;
    endfunction

    function automatic logic [7:0] tx_at(input int idx);
        if (idx < tx_q.size()) return tx_q[idx];
        return 8'hxx;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus.enc_data, bus.tx_byte, bus.enc_start, bus.tx_valid, bus.busy, bus.overrun,
             bus.rx_timeout, bus.enc_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_in: enc_data=%h tx_byte=%h st=%b v=%b busy=%b ovr=%b rxto=%b encto=%b exp all 0",
                     bus.enc_data, bus.tx_byte, bus.enc_start, bus.tx_valid, bus.busy,
                     bus.overrun, bus.rx_timeout, bus.enc_timeout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        checks++;
        if ({bus.enc_data, bus.tx_byte, bus.enc_start, bus.tx_valid, bus.busy, bus.overrun,
             bus.rx_timeout, bus.enc_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_after: enc_data=%h tx_v=%b busy=%b exp all 0",
                     bus.enc_data, bus.tx_valid, bus.busy);
        end
    endtask

    task automatic test_basic();
        int s_start, t0;
        bit ok;
        ready_mode = 0; core_lat = 50; core_never = 1'b0;
        for (int i = 0; i < 16; i++) pb[i] = 8'(i);
        s_start = n_start; t0 = tx_q.size();
        send_block(0);
        wait_tx(t0 + 16, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_tx_wait: got %0d bytes exp 16", tx_q.size() - t0); end
        checks++;
        if (start_data !== 128'h000102030405060708090a0b0c0d0e0f) begin
            failures++; $display("FAIL basic_block: got %h exp 000102..0f", start_data);
        end
        checks++;
        if (n_start - s_start !== 1) begin
            failures++; $display("FAIL basic_start_cnt: got %0d exp 1", n_start - s_start);
        end
        checks++;
        if (start_cyc - last_rx_cyc !== 2) begin
            failures++; $display("FAIL basic_start_lat: got %0d exp 2", start_cyc - last_rx_cyc);
        end
        checks++;
        if (first_tx_cyc - done_cyc !== 1) begin
            failures++; $display("FAIL basic_tx_lat: got %0d exp 1", first_tx_cyc - done_cyc);
        end
        checks++;
        if (done_data !== start_data) begin
            failures++; $display("FAIL basic_hold: got %h exp %h", done_data, start_data);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_at(t0 + i) !== ~pb[i]) begin
                failures++; $display("FAIL basic_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
            end
        end
        idle(5);
        checks++;
        if ({bus.busy, bus.tx_valid} !== 2'b00 || tx_q.size() - t0 !== 16) begin
            failures++;
            $display("FAIL basic_end: busy=%b tx_valid=%b bytes=%0d exp 0 0 16",
                     bus.busy, bus.tx_valid, tx_q.size() - t0);
        end
    endtask

    task automatic test_back_to_back();
        int t0, sv0;
        bit ok;
        logic [127:0] exp;
        ready_mode = 1;
        for (int b = 0; b < 3; b++) begin
            rand_block();
            core_lat = int'($urandom_range(80, 1));
            t0 = tx_q.size(); sv0 = n_stall_viol;
            send_block(3);
            exp = model_block();
            wait_tx(t0 + 16, 600, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL b2b_tx_wait[%0d]: got %0d exp 16", b, tx_q.size() - t0); end
            checks++;
            if (start_data !== exp) begin
                failures++; $display("FAIL b2b_block[%0d]: got %h exp %h", b, start_data, exp);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (tx_at(t0 + i) !== ~pb[i]) begin
                    failures++; $display("FAIL b2b_tx[%0d][%0d]: got %h exp %h", b, i, tx_at(t0 + i), ~pb[i]);
                end
            end
            checks++;
            if (n_stall_viol - sv0 !== 0) begin
                failures++; $display("FAIL b2b_stall[%0d]: got %0d changes exp 0", b, n_stall_viol - sv0);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0, sv0;
        bit ok;
        ready_mode = 2; core_lat = 10;
        rand_block();
        t0 = tx_q.size(); sv0 = n_stall_viol;
        send_block(1);
        wait_tx(t0 + 16, 400, ok);
        idle(8);
        checks++;
        if (!ok || tx_q.size() - t0 !== 16) begin
            failures++; $display("FAIL bp_count: got %0d bytes exp 16", tx_q.size() - t0);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_at(t0 + i) !== ~pb[i]) begin
                failures++; $display("FAIL bp_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
            end
        end
        checks++;
        if (n_stall_viol - sv0 !== 0) begin
            failures++; $display("FAIL bp_stable: got %0d changes while stalled exp 0", n_stall_viol - sv0);
        end
        ready_mode = 0;
    endtask

    task automatic test_rx_timeout();
        int r0, s0, t0;
        bit ok;
        logic [127:0] exp;
        ready_mode = 0; core_lat = 20;
        r0 = n_rxto;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL rxto_busy_partial: got %b exp 1", bus.busy); end
        idle(IdleMax + 5);
        checks++;
        if (n_rxto - r0 !== 1) begin failures++; $display("FAIL rxto_count: got %0d exp 1", n_rxto - r0); end
        checks++;
        if (rxto_cyc - last_rx_cyc !== IdleMax + 1) begin
            failures++; $display("FAIL rxto_time: got %0d exp %0d", rxto_cyc - last_rx_cyc, IdleMax + 1);
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rxto_busy: got %b exp 0", bus.busy); end
        // clean block after the discard
        rand_block();
        t0 = tx_q.size();
        send_block(2);
        exp = model_block();
        wait_tx(t0 + 16, 300, ok);
        checks++;
        if (start_data !== exp) begin failures++; $display("FAIL rxto_clean: got %h exp %h", start_data, exp); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_at(t0 + i) !== ~pb[i]) begin
                failures++; $display("FAIL rxto_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
            end
        end
        // a byte landing on the timeout cycle starts a fresh block
        r0 = n_rxto; s0 = n_start;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom()));
        idle(IdleMax - 1);
        rand_block();
        t0 = tx_q.size();
        send_block(0);
        exp = model_block();
        wait_tx(t0 + 16, 300, ok);
        checks++;
        if (n_rxto - r0 !== 1) begin failures++; $display("FAIL rxto_sim_count: got %0d exp 1", n_rxto - r0); end
        checks++;
        if (n_start - s0 !== 1 || start_data !== exp) begin
            failures++;
            $display("FAIL rxto_sim_block: starts=%0d data=%h exp 1 %h", n_start - s0, start_data, exp);
        end
    endtask

    task automatic test_wait_timeout();
        int e0, s0, t0;
        for (int m = 0; m < 3; m++) begin
            // m=0: core never answers, m=1: answers one cycle too late,
            // m=2: answers on exactly the last allowed cycle
            core_never = (m == 0);
            core_lat   = (m == 1) ? EncMax + 1 : EncMax;
            ready_mode = 0;
            rand_block();
            e0 = n_encto; s0 = n_start; t0 = tx_q.size();
            send_block(2);
            idle(EncMax + 40);
            checks++;
            if (n_start - s0 !== 1) begin failures++; $display("FAIL wto_start[%0d]: got %0d exp 1", m, n_start - s0); end
            if (m < 2) begin
                checks++;
                if (n_encto - e0 !== 1) begin failures++; $display("FAIL wto_count[%0d]: got %0d exp 1", m, n_encto - e0); end
                checks++;
                if (encto_cyc - start_cyc !== EncMax + 1) begin
                    failures++; $display("FAIL wto_time[%0d]: got %0d exp %0d", m, encto_cyc - start_cyc, EncMax + 1);
                end
                checks++;
                if (tx_q.size() - t0 !== 0 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL wto_idle[%0d]: bytes=%0d busy=%b tx_valid=%b exp 0 0 0",
                             m, tx_q.size() - t0, bus.busy, bus.tx_valid);
                end
            end else begin
                checks++;
                if (n_encto - e0 !== 0) begin failures++; $display("FAIL wto_done_wins: got %0d timeouts exp 0", n_encto - e0); end
                checks++;
                if (tx_q.size() - t0 !== 16) begin failures++; $display("FAIL wto_done_bytes: got %0d exp 16", tx_q.size() - t0); end
                for (int i = 0; i < 16; i++) begin
                    checks++;
                    if (tx_at(t0 + i) !== ~pb[i]) begin
                        failures++; $display("FAIL wto_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
                    end
                end
            end
        end
        core_never = 1'b0;
    endtask

    task automatic test_overrun();
        int o0, t0;
        bit ok;
        logic [127:0] exp;
        ready_mode = 0; core_lat = 40;
        rand_block();
        o0 = n_ovr; t0 = tx_q.size();
        send_block(0);
        idle(10);
        send_byte(8'hAA);
        wait_tx(t0 + 16, 300, ok);
        checks++;
        if (n_ovr - o0 !== 1) begin failures++; $display("FAIL ovr_count: got %0d exp 1", n_ovr - o0); end
        checks++;
        if (ovr_cyc - last_rx_cyc !== 1) begin failures++; $display("FAIL ovr_time: got %0d exp 1", ovr_cyc - last_rx_cyc); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_at(t0 + i) !== ~pb[i]) begin
                failures++; $display("FAIL ovr_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
            end
        end
        rand_block();
        t0 = tx_q.size();
        send_block(1);
        exp = model_block();
        wait_tx(t0 + 16, 300, ok);
        checks++;
        if (start_data !== exp) begin failures++; $display("FAIL ovr_next_block: got %h exp %h", start_data, exp); end
    endtask

    task automatic test_reset_mid_send();
        int t0;
        bit ok;
        logic [127:0] exp;
        ready_mode = 0; core_lat = 20;
        rand_block();
        t0 = tx_q.size();
        send_block(0);
        wait_tx(t0 + 7, 300, ok);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.enc_data, bus.tx_byte, bus.enc_start, bus.tx_valid, bus.busy, bus.overrun,
             bus.rx_timeout, bus.enc_timeout} !== '0) begin
            failures++;
            $display("FAIL rst_async: enc_data=%h tx_byte=%h tx_valid=%b busy=%b exp all 0",
                     bus.enc_data, bus.tx_byte, bus.tx_valid, bus.busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(30);
        checks++;
        if (!ok || tx_q.size() - t0 !== 7) begin
            failures++; $display("FAIL rst_no_tail: got %0d bytes exp 7", tx_q.size() - t0);
        end
        checks++;
        if ({bus.busy, bus.tx_valid} !== 2'b00) begin
            failures++; $display("FAIL rst_idle: busy=%b tx_valid=%b exp 0 0", bus.busy, bus.tx_valid);
        end
        rand_block();
        t0 = tx_q.size();
        send_block(2);
        exp = model_block();
        wait_tx(t0 + 16, 300, ok);
        checks++;
        if (start_data !== exp) begin failures++; $display("FAIL rst_fresh_block: got %h exp %h", start_data, exp); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_at(t0 + i) !== ~pb[i]) begin
                failures++; $display("FAIL rst_fresh_tx[%0d]: got %h exp %h", i, tx_at(t0 + i), ~pb[i]);
            end
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'd0;
        rst          = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_rx_timeout();
        test_wait_timeout();
        test_overrun();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
